// File: rtl/bus_uart_tx_if.sv
// bus_uart_tx_if: device-slot bus signals between a bus master and bus_uart_tx
interface bus_uart_tx_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) ();
   logic [AddrWidth-1:0] bus_addr;
   logic                 bus_re;
   logic                 bus_we;
   logic [DataWidth-1:0] bus_wdata;
   logic [DataWidth-1:0] bus_rdata;
   logic                 bus_gnt;
   modport master (output bus_addr, bus_re, bus_we, bus_wdata, input bus_rdata, bus_gnt);
   modport slave (input bus_addr, bus_re, bus_we, bus_wdata, output bus_rdata, bus_gnt);
endinterface

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, baud divider and status.
// Define UART_TX_PARITY_EN to add a programmable parity bit (BAUDDIV[17:16]).
module bus_uart_tx #(
   parameter int          AddrWidth   = 32,
   parameter int          DataWidth   = 32,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic         clk_i,
   input  logic         rst_i,
   bus_uart_tx_if.slave bus,
   output logic         tx_o,
   output logic         irq_o
);
   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
      , PARITY
`endif
   } state_e;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wdata, rd_val, rdata_q;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wp_q, rp_q, cnt;
   logic [15:0]          div_q, div_act_q, bcnt_q;
   logic [7:0]           shift_q;
   logic [2:0]           bit_q;
   logic [1:0]           sel;
   state_e               state_q;
   logic                 gnt_q, tx_q, full, empty, acc, wr, push, tick, unused;
`ifdef UART_TX_PARITY_EN
   logic                 par_en_q, par_odd_q;
`endif
   assign addr        = bus.bus_addr;
   assign wdata       = bus.bus_wdata;
   assign sel         = addr[3:2];
   assign cnt         = wp_q - rp_q;
   assign empty       = cnt == '0;
   assign full        = cnt == PW'(FIFO_DEPTH);
   // a TXDATA write into a full FIFO waits without a grant
   assign acc         = (bus.bus_re | bus.bus_we) & ~gnt_q & ~(bus.bus_we & sel == 2'd0 & full);
   assign wr          = acc & bus.bus_we;
   assign push        = wr & sel == 2'd0;
   assign tick        = bcnt_q == div_act_q - 16'd1;
   assign bus.bus_gnt   = gnt_q;
   assign bus.bus_rdata = rdata_q;
   assign tx_o        = tx_q;
   assign irq_o       = empty & state_q == IDLE;
   assign unused      = ^{addr[AddrWidth-1:4], addr[1:0], wdata[DataWidth-1:16]};
   always_comb begin
      rd_val = '0;
      if (sel == 2'd1) rd_val[15:0] = {8'(cnt), 5'd0, state_q != IDLE, empty, full};
      if (sel == 2'd2) rd_val[15:0] = div_q;
`ifdef UART_TX_PARITY_EN
      if (sel == 2'd2) rd_val[17:16] = {par_odd_q, par_en_q};
`endif
   end
   always_ff @(posedge clk_i) if (push) mem_q[wp_q[PW-2:0]] <= wdata[7:0];
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         gnt_q     <= 1'b0;
         rdata_q   <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         div_q     <= DEFAULT_DIV;
         div_act_q <= DEFAULT_DIV;
         bcnt_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         state_q   <= IDLE;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
`endif
      end else begin
         gnt_q   <= acc;
         rdata_q <= acc & ~bus.bus_we ? rd_val : '0;
         if (push) wp_q <= wp_q + PW'(1);
         if (wr & sel == 2'd2) begin
            div_q <= wdata[15:0] == 16'd0 ? 16'd1 : wdata[15:0];
`ifdef UART_TX_PARITY_EN
            par_en_q  <= wdata[16];
            par_odd_q <= wdata[17];
`endif
         end
         // divider changes are picked up only at bit boundaries
         bcnt_q <= state_q == IDLE | tick ? 16'd0 : bcnt_q + 16'd1;
         if (state_q == IDLE | tick) div_act_q <= div_q;
         case (state_q)
            IDLE: if (!empty) begin
               shift_q <= mem_q[rp_q[PW-2:0]];
               rp_q    <= rp_q + PW'(1);
               tx_q    <= 1'b0;
               state_q <= START;
            end
            START: if (tick) begin
               tx_q    <= shift_q[0];
               bit_q   <= 3'd0;
               state_q <= DATA;
            end
            DATA: if (tick) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_q    <= par_en_q ? (par_odd_q ? ~^shift_q : ^shift_q) : 1'b1;
                  state_q <= par_en_q ? PARITY : STOP;
`else
                  tx_q    <= 1'b1;
                  state_q <= STOP;
`endif
               end else begin
                  bit_q <= bit_q + 3'd1;
                  tx_q  <= shift_q[bit_q + 3'd1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
               tx_q    <= 1'b1;
               state_q <= STOP;
            end
`endif
            STOP: if (tick) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
